// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
// card_shoe : 52-card deck, LFSR-driven Fisher-Yates shuffle, one-cycle dealer
// Revision  : 1.0
// ============================================================================
module card_shoe #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       shuffle_req,
    input  logic       deal_req,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic       card_is_ace,
    output logic       busy,
    output logic       empty,
    output logic [5:0] cards_left
);

    localparam logic [5:0]  C_DECK_SIZE = 6'd52;
    localparam logic [5:0]  C_LAST_ID   = 6'd51;
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_PICK  = 2'd1,
        S_SWAP  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  deck_q [0:51];
    logic [5:0]  deck_d [0:51];
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  j_q, j_d;
    logic [5:0]  ptr_q, ptr_d;
    logic        card_valid_q, card_valid_d;
    logic [3:0]  card_rank_q, card_rank_d;
    logic [3:0]  card_value_q, card_value_d;
    logic        card_is_ace_q, card_is_ace_d;
    logic        busy_q, busy_d;

    logic [5:0]  w_mask;
    logic [5:0]  w_cand;
    logic [3:0]  w_deal_rank;

    function automatic logic [3:0] rank_of(input logic [5:0] id);
        logic [5:0] r;
        if (id < 6'd13)      r = id + 6'd1;
        else if (id < 6'd26) r = id - 6'd12;
        else if (id < 6'd39) r = id - 6'd25;
        else                 r = id - 6'd38;
        return r[3:0];
    endfunction

    // Smallest all-ones mask covering 0..i, so rejection sampling stays unbiased
    always_comb begin
        if (idx_q >= 6'd32)      w_mask = 6'd63;
        else if (idx_q >= 6'd16) w_mask = 6'd31;
        else if (idx_q >= 6'd8)  w_mask = 6'd15;
        else if (idx_q >= 6'd4)  w_mask = 6'd7;
        else if (idx_q >= 6'd2)  w_mask = 6'd3;
        else                     w_mask = 6'd1;
    end

    assign w_cand      = lfsr_q[5:0] & w_mask;
    assign w_deal_rank = rank_of(deck_q[ptr_q]);

    always_comb begin
        state_d       = state_q;
        lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_LFSR_TAPS : 16'h0000);
        deck_d        = deck_q;
        idx_d         = idx_q;
        j_d           = j_q;
        ptr_d         = ptr_q;
        card_valid_d  = 1'b0;
        card_rank_d   = card_rank_q;
        card_value_d  = card_value_q;
        card_is_ace_d = card_is_ace_q;

        case (state_q)
            S_INIT: begin
                deck_d[idx_q] = idx_q;
                ptr_d         = 6'd0;
                if (idx_q == C_LAST_ID) begin
                    idx_d   = C_LAST_ID;
                    state_d = S_PICK;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_PICK: begin
                if (w_cand <= idx_q) begin
                    j_d     = w_cand;
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                deck_d[idx_q] = deck_q[j_q];
                deck_d[j_q]   = deck_q[idx_q];
                if (idx_q == 6'd1) begin
                    state_d = S_READY;
                end else begin
                    idx_d   = idx_q - 6'd1;
                    state_d = S_PICK;
                end
            end
            S_READY: begin
                if (shuffle_req) begin
                    idx_d   = 6'd0;
                    ptr_d   = 6'd0;
                    state_d = S_INIT;
                end else if (deal_req && (ptr_q < C_DECK_SIZE)) begin
                    card_valid_d  = 1'b1;
                    card_rank_d   = w_deal_rank;
                    card_value_d  = (w_deal_rank > 4'd10) ? 4'd10 : w_deal_rank;
                    card_is_ace_d = (w_deal_rank == 4'd1);
                    ptr_d         = ptr_q + 6'd1;
                end
            end
            default: begin
                idx_d   = 6'd0;
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_READY);
    end

    // Deck contents need no reset: INIT rewrites every entry before use
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= S_INIT;
            lfsr_q        <= SEED;
            idx_q         <= 6'd0;
            j_q           <= 6'd0;
            ptr_q         <= 6'd0;
            card_valid_q  <= 1'b0;
            card_rank_q   <= 4'd0;
            card_value_q  <= 4'd0;
            card_is_ace_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            deck_q        <= deck_d;
            idx_q         <= idx_d;
            j_q           <= j_d;
            ptr_q         <= ptr_d;
            card_valid_q  <= card_valid_d;
            card_rank_q   <= card_rank_d;
            card_value_q  <= card_value_d;
            card_is_ace_q <= card_is_ace_d;
            busy_q        <= busy_d;
        end
    end

    assign card_valid  = card_valid_q;
    assign card_rank   = card_rank_q;
    assign card_value  = card_value_q;
    assign card_is_ace = card_is_ace_q;
    assign busy        = busy_q;
    assign empty       = (ptr_q == C_DECK_SIZE);
    assign cards_left  = C_DECK_SIZE - ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
// tb_card_shoe : self-checking bench for card_shoe (deck accounting model)
// Revision     : 1.0
// ============================================================================
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       shuffle_req;
    logic       deal_req;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic       card_is_ace;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;

    always #5 clk = ~clk;

    card_shoe #(.SEED(16'hACE1)) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .shuffle_req (shuffle_req),
        .deal_req    (deal_req),
        .card_valid  (card_valid),
        .card_rank   (card_rank),
        .card_value  (card_value),
        .card_is_ace (card_is_ace),
        .busy        (busy),
        .empty       (empty),
        .cards_left  (cards_left)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] seq_q[$];
    logic [3:0] seq_a[$];
    logic [3:0] seq_b[$];
    int         cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Blackjack value straight from the rank rules
    function automatic logic [31:0] value_of(input logic [3:0] r);
        if (r >= 4'd11) return 32'd10;
        return {28'd0, r};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; shuffle_req = 1'b0; deal_req = 1'b0;
        @(negedge clk);
        chk("rst_valid", card_valid, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_value", card_value, 0);
        chk("rst_ace", card_is_ace, 0);
        chk("rst_busy", busy, 1);
        chk("rst_empty", empty, 0);
        chk("rst_left", cards_left, 52);
        reset_n = 1'b1;
    endtask

    // Counts cycles until busy drops; optionally fires stray deal requests
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            deal_req = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
            if (poke) begin
                chk("busy_no_valid", card_valid, 0);
                chk("busy_left", cards_left, 52);
            end
        end
        deal_req = 1'b0;
        chk("ready_reached", busy, 0);
    endtask

    task automatic pulse_shuffle(input bit with_deal);
        shuffle_req = 1'b1; deal_req = with_deal;
        @(negedge clk);
        shuffle_req = 1'b0; deal_req = 1'b0;
        chk("shuf_no_valid", card_valid, 0);
        chk("shuf_busy", busy, 1);
        chk("shuf_left", cards_left, 52);
    endtask

    task automatic deal_all(input int max_gap);
        int hist[14];
        int gap;
        for (int r = 0; r < 14; r++) hist[r] = 0;
        seq_q.delete();
        for (int n = 0; n < 52; n++) begin
            gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
            repeat (gap) begin
                deal_req = 1'b0;
                @(negedge clk);
                chk("gap_no_valid", card_valid, 0);
            end
            deal_req = 1'b1;
            @(negedge clk);
            chk("deal_valid", card_valid, 1);
            chk("rank_range", (card_rank >= 4'd1 && card_rank <= 4'd13), 1);
            if (card_rank >= 4'd1 && card_rank <= 4'd13) begin
                chk("rank_quota", (hist[card_rank] < 4), 1);
                hist[card_rank]++;
            end
            chk("value_map", card_value, value_of(card_rank));
            chk("ace_flag", card_is_ace, (card_rank == 4'd1));
            chk("cards_left", cards_left, 51 - n);
            chk("empty_flag", empty, (n == 51));
            seq_q.push_back(card_rank);
        end
        deal_req = 1'b0;
        for (int r = 1; r < 14; r++) chk("rank_hist", hist[r], 4);
    endtask

    function automatic int count_diffs();
        int d = 0;
        for (int k = 0; k < 52; k++) if (seq_a[k] !== seq_b[k]) d++;
        return d;
    endfunction

    initial begin
        logic [3:0] last;
        // Full deal with random spacing, stray requests while shuffling
        do_reset();
        wait_ready(1'b1, cyc);
        chk("shuffle_min_len", (cyc >= 154), 1);
        deal_all(3);

        // Exhaustion: cards hold, no pulses
        last = seq_q[51];
        repeat (3) begin
            deal_req = 1'b1;
            @(negedge clk);
            chk("exh_no_valid", card_valid, 0);
            chk("exh_hold_rank", card_rank, last);
            chk("exh_empty", empty, 1);
            chk("exh_left", cards_left, 0);
        end
        deal_req = 1'b0;

        // Collision on an empty deck, then on a partly dealt one
        pulse_shuffle(1'b1);
        wait_ready(1'b1, cyc);
        for (int n = 0; n < 5; n++) begin
            deal_req = 1'b1;
            @(negedge clk);
            chk("part_valid", card_valid, 1);
            chk("part_left", cards_left, 51 - n);
        end
        deal_req = 1'b0;
        @(negedge clk);
        pulse_shuffle(1'b1);
        wait_ready(1'b0, cyc);
        deal_all(2);

        // Determinism: identical timing gives identical sequences
        do_reset();
        wait_ready(1'b0, cyc);
        deal_all(0);
        seq_a = seq_q;
        do_reset();
        wait_ready(1'b0, cyc);
        deal_all(0);
        seq_b = seq_q;
        chk("det_same", count_diffs(), 0);

        // One cycle of shuffle delay changes the order
        do_reset();
        wait_ready(1'b0, cyc);
        repeat (5) @(negedge clk);
        pulse_shuffle(1'b0);
        wait_ready(1'b0, cyc);
        deal_all(0);
        seq_a = seq_q;
        do_reset();
        wait_ready(1'b0, cyc);
        repeat (6) @(negedge clk);
        pulse_shuffle(1'b0);
        wait_ready(1'b0, cyc);
        deal_all(0);
        seq_b = seq_q;
        chk("delay_differs", (count_diffs() != 0), 1);

        // Reset mid-shuffle at cycle 80
        do_reset();
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            chk("mid_busy", busy, 1);
        end
        do_reset();
        wait_ready(1'b0, cyc);
        chk("restart_min_len", (cyc >= 154), 1);
        deal_all(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_shoe.md
# card_shoe

Upstream card source for the blackjack game FSM. It holds one 52-card deck and shuffles it in hardware with an LFSR-driven Fisher-Yates pass. It deals cards without repetition on a one-cycle request/valid handshake. This replaces the free-running per-cycle random card, so the game sees realistic draw statistics and exhaustible cards.

## Interface
- SEED, 16'hACE1: LFSR load value on reset; must be non-zero.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; the top level drives it from KEY[2].
- shuffle_req  in  1  single-cycle pulse; starts a new deck and shuffle.
- deal_req  in  1  single-cycle pulse; requests the next card.
- card_valid  out  1  one-cycle pulse; the card outputs are new this cycle.
- card_rank  out  4  rank: 1 = Ace, 2–10, 11 = J, 12 = Q, 13 = K.
- card_value  out  4  blackjack value: Ace = 1, face cards = 10, else the rank.
- card_is_ace  out  1  high when card_rank == 1.
- busy  out  1  high while initialising or shuffling; requests are not serviced.
- empty  out  1  high when all 52 cards have been dealt.
- cards_left  out  6  number of undealt cards, 0–52.

## Operation
- **Storage:** deck[0:51], each entry a 6-bit card id 0–51.
  - rank = id % 13 + 1
  - suit = id / 13 (internal only)
  - Deal pointer ptr is 6 bits; cards_left = 52 − ptr.
- **LFSR:** 16-bit maximal-length Galois LFSR, loaded with SEED on reset.
  - It advances every cycle in every state.
  - Because it runs freely, the time at which shuffle_req arrives seeds the shuffle.
- **States:** INIT, PICK, SWAP, READY.
- **INIT:** writes deck[k] = k for k = 0..51, one entry per cycle (52 cycles), with ptr = 0.
  - Then i = 51 and the FSM goes to PICK.
- **PICK:** takes candidate j = lfsr & mask(i), where mask(i) = 2^ceil(log2(i+1)) − 1.
  - If j ≤ i, latch j and go to SWAP.
  - Otherwise stay in PICK and retry on the next cycle (rejection sampling, no modulo bias).
- **SWAP:** exchanges deck[i] and deck[j] in a single cycle. j == i is a legal no-op.
  - If i == 1, go to READY.
  - Otherwise decrement i and return to PICK.
- **READY:** services requests. Priority is reset, then shuffle_req, then deal_req.
  - shuffle_req: go to INIT; any dealt cards return to the deck.
  - deal_req with ptr < 52: present deck[ptr], then ptr++.
  - deal_req with ptr == 52: ignored. No card_valid; empty stays 1.
- **Ignored requests:**
  - shuffle_req and deal_req are both ignored in INIT, PICK and SWAP.
  - Callers must poll busy.
- **Output hold:** card_rank, card_value and card_is_ace hold their last dealt value until the next deal.

## Timing
- **Reset values:**
  - card_valid = 0, card_rank = 0, card_value = 0, card_is_ace = 0.
  - busy = 1, empty = 0, cards_left = 52.
  - State = INIT.
- **busy:** high from the cycle after reset release or an accepted shuffle_req until READY is entered.
- **Shuffle time:** minimum 52 + 51×2 = 154 cycles. Rejections extend this.
  - Mean rejection overhead per step is below 1 cycle.
  - No bound beyond the LFSR period is guaranteed.
- **Deal latency:** deal_req accepted in cycle N gives card_valid = 1 and new card fields in cycle N+1.
  - cards_left and empty update in N+1.
  - Back-to-back deal_req on consecutive cycles is allowed; each one yields one card.
- **Simultaneous requests in READY:** shuffle_req wins. No card_valid is produced; busy = 1 in the next cycle.
- **Reset mid-operation:** reset_n low on any edge returns all outputs to reset values on that edge.
  - No partial card_valid is produced.
  - The shuffle restarts from INIT with the LFSR at SEED.
- **empty:** asserts in the same cycle as the card_valid of the 52nd card.

## Test plan
- **Full deal:** reset, wait for busy = 0, issue 52 deal_req.
  - Required: 52 card_valid pulses.
  - Ids form a permutation of 0–51, so each rank appears exactly 4 times.
  - cards_left steps 52→0; empty rises with the 52nd card.
- **Exhaustion:** after the full deal, issue 3 more deal_req.
  - Required: no card_valid; card fields hold the 52nd card; empty = 1; cards_left = 0.
- **Value mapping across the full deal:**
  - rank 1 gives value 1 and is_ace = 1.
  - ranks 11/12/13 give value 10 and is_ace = 0.
  - rank 7 gives value 7.
- **Determinism:**
  - Two runs with SEED = 16'hACE1 and identical stimulus timing give identical sequences.
  - Delaying shuffle_req by 1 cycle gives a different sequence.
- **Reset mid-shuffle:** assert reset_n = 0 for one cycle at cycle 80 after release.
  - Required: busy stays 1 and INIT restarts.
  - The subsequent full deal is still a valid permutation.
- **Request collisions:**
  - In READY, deal_req and shuffle_req in the same cycle: no card_valid, busy = 1 next cycle, cards_left = 52.
  - deal_req while busy: ignored, no pulse.
